// File: rtl/ps2_receiver_pkg.sv
// Shared types for the PS/2 receive path and its consumers.
package common;

    typedef logic [7:0] byte_t;

    localparam int FRAME_BITS = 11;

    // Frame bits in arrival order: [0] start, [8:1] data, [9] parity, [10] stop.
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
        return !f[0] && f[10] && (^f[9:1]);
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer followed by a saturating level filter.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic level
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            s1 <= line;
            s2 <= s1;
            // Any sample that agrees with the current level restarts the run.
            if (s2 != level) begin
                if (cnt == CW'(FILTER_LEN - 1)) begin
                    level <= s2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: deglitch, deserialize, check, strobe.
module ps2_receiver
    import common::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic  clk_i,
    input  logic  reset_i,
    input  logic  ps2_clk_async_i,
    input  logic  ps2_data_async_i,
    output byte_t data_o,
    output logic  valid_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic                  clk_f;
    logic                  data_f;
    logic                  clk_prev;
    logic                  fall;
    logic                  done;
    logic [3:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shift;
    logic [TW-1:0]         tcnt;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk_i),
        .rst_n (reset_i),
        .line  (ps2_clk_async_i),
        .level (clk_f)
    );

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk_i),
        .rst_n (reset_i),
        .line  (ps2_data_async_i),
        .level (data_f)
    );

    assign fall = clk_prev & ~clk_f;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            clk_prev <= 1'b1;
            done     <= 1'b0;
            bit_cnt  <= '0;
            shift    <= '0;
            tcnt     <= '0;
            data_o   <= '0;
            valid_o  <= 1'b0;
        end else begin
            clk_prev <= clk_f;
            done     <= 1'b0;
            valid_o  <= 1'b0;
            // Checked one cycle after the stop bit lands in the shifter.
            if (done && frame_ok(shift)) begin
                data_o  <= shift[8:1];
                valid_o <= 1'b1;
            end
            if (fall) begin
                shift <= {data_f, shift[FRAME_BITS-1:1]};
                tcnt  <= '0;
                if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                    bit_cnt <= '0;
                    done    <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (bit_cnt == '0) begin
                tcnt <= '0;
            end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt <= '0;
                tcnt    <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_receiver.sv
// Scoreboard bench for ps2_receiver with randomized PS/2 frames.
module tb_ps2_receiver;
    import common::*;

    typedef struct {
        byte_t data;
        int    due;
    } exp_t;

    logic  clk      = 1'b0;
    logic  reset_i  = 1'b0;
    logic  ps2_clk  = 1'b1;
    logic  ps2_data = 1'b1;
    byte_t data_o;
    logic  valid_o;

    int    cyc         = 0;
    int    vectors     = 0;
    int    miscompares = 0;
    int    fall_cyc    = 0;
    byte_t last_good   = 8'h00;
    bit    mon_prev    = 1'b0;
    exp_t  sbq[$];
    exp_t  mon_e;

    ps2_receiver dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .ps2_clk_async_i  (ps2_clk),
        .ps2_data_async_i (ps2_data),
        .data_o           (data_o),
        .valid_o          (valid_o)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_o) begin
            vectors++;
            if (mon_prev) begin
                miscompares++;
                $display("FAIL double_pulse: valid_o high two cycles at cyc %0d", cyc);
            end else if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_pulse: data_o=%h, none expected", data_o);
            end else begin
                mon_e = sbq.pop_front();
                if (data_o !== mon_e.data || cyc != mon_e.due) begin
                    miscompares++;
                    $display("FAIL rx_byte: got %h at cyc %0d, expected %h at cyc %0d",
                             data_o, cyc, mon_e.data, mon_e.due);
                end
            end
        end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
            vectors++;
            miscompares++;
            $display("FAIL missing_pulse: got nothing, expected %h at cyc %0d",
                     sbq[0].data, sbq[0].due);
            void'(sbq.pop_front());
        end
        mon_prev = valid_o;
    end

    task automatic check8(input string name, input logic [7:0] act,
                          input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference frame: odd parity means data ones plus parity bit is odd.
    function automatic logic [10:0] make_frame(input byte_t b, input bit bad_par,
                                               input bit bad_start, input bit bad_stop);
        int  ones = 0;
        logic par;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        return {~bad_stop, par ^ bad_par, b, bad_start};
    endfunction

    function automatic bit frame_good(input logic [10:0] f);
        int ones = 0;
        for (int i = 1; i <= 9; i++) ones += int'(f[i]);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && ((ones % 2) == 1);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Data set 200 ns before each fall, 1 us low, 1 us high.
    task automatic send_bits(input logic [10:0] f, input int n, input bit glitch);
        exp_t t;
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            idle(10);
            ps2_clk = 1'b0;
            if (i == 10) begin
                fall_cyc = cyc;
                if (frame_good(f)) begin
                    t.data = f[8:1];
                    t.due  = fall_cyc + 12;
                    sbq.push_back(t);
                    last_good = f[8:1];
                end
            end
            idle(50);
            ps2_clk = 1'b1;
            if (glitch && i < 10) begin
                idle(15);
                #5 ps2_clk = 1'b0;
                #60 ps2_clk = 1'b1;
                idle(22);
            end else begin
                idle(40);
            end
        end
    endtask

    task automatic send_frame(input byte_t b, input bit bad_par, input bit bad_start,
                              input bit bad_stop, input bit glitch);
        send_bits(make_frame(b, bad_par, bad_start, bad_stop), 11, glitch);
    endtask

    initial begin
        logic [10:0] f;
        idle(3);
        check8("reset_data", data_o, 8'h00);
        check8("reset_valid", {7'b0, valid_o}, 8'h00);
        reset_i = 1'b1;
        idle(20);

        send_frame(8'h76, 0, 0, 0, 0);
        idle(100);
        check8("good_76_hold", data_o, 8'h76);

        send_frame(8'h1C, 1, 0, 0, 0);
        idle(100);
        check8("bad_parity_hold", data_o, 8'h76);
        send_frame(8'h5A, 0, 0, 0, 0);
        idle(100);

        send_frame(8'hF0, 0, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0, 0);
        idle(100);

        send_frame(8'h29, 0, 0, 0, 1);
        idle(100);
        check8("glitch_29_hold", data_o, 8'h29);

        f = make_frame(8'hAA, 0, 0, 0);
        send_bits(f, 4, 0);
        idle(5200);
        send_frame(8'h45, 0, 0, 0, 0);
        idle(100);
        check8("timeout_45_hold", data_o, 8'h45);

        f = make_frame(8'h3C, 0, 0, 0);
        send_bits(f, 5, 0);
        ps2_data = f[5];
        idle(10);
        ps2_clk = 1'b0;
        idle(20);
        #3 reset_i = 1'b0;
        #1;
        check8("midframe_reset_data", data_o, 8'h00);
        check8("midframe_reset_valid", {7'b0, valid_o}, 8'h00);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        last_good = 8'h00;
        idle(5);
        reset_i = 1'b1;
        idle(30);
        send_frame(8'h76, 0, 0, 0, 0);
        idle(100);
        check8("after_reset_76", data_o, 8'h76);

        for (int n = 0; n < 16; n++) begin
            int sel;
            sel = $urandom_range(0, 7);
            send_frame(byte_t'($urandom), sel == 0, sel == 1, sel == 2,
                       $urandom_range(0, 2) == 0);
            idle($urandom_range(0, 50));
        end
        idle(100);
        check8("final_data", data_o, last_good);
        check8("scoreboard_empty", 8'(sbq.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
